// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction fetch stage: the fetch FSM state
//   encoding, the NOP word shown on the output while nothing has been
//   fetched, and the default datapath width and reset PC.
package fetch_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_FLUSH
  } fetch_state_t;

endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder
//   Forms the taken-branch target br_pc + imm_ext (wrapping modulo 2^XLEN),
//   presents its word-aligned form for the PC, and flags a target whose
//   bit 1 is set so the fetch stage can raise its misalign pulse.
// Ports
//   br_taken      in   1     redirect pulse; gates misalign_next
//   br_pc         in   XLEN  PC of the redirecting branch
//   imm_ext       in   XLEN  sign-extended B-type immediate
//   tgt_aligned   out  XLEN  {tgt[XLEN-1:2], 2'b00}
//   misalign_next out  1     br_taken & tgt[1]
module branch_target_adder
  import fetch_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] tgt_aligned,
  output logic            misalign_next
);

  logic [XLEN-1:0] tgt;
  logic            tgt_bit0_unused;

  assign tgt = br_pc + imm_ext;

  // Fetches are always word aligned, so the low two bits are dropped from
  // the PC; bit 1 is still reported because it means the target was not a
  // valid 4-byte instruction address. Bit 0 carries no meaning here.
  assign tgt_aligned     = {tgt[XLEN-1:2], 2'b00};
  assign misalign_next   = br_taken & tgt[1];
  assign tgt_bit0_unused = tgt[0];

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
//   Holds the PC and keeps one request outstanding to instruction memory.
//   Each returned word is registered with its PC for the decoder. A word
//   that arrives while decode is stalled is parked in hold_inst and no new
//   request is issued until it drains. A taken branch redirects the PC to
//   br_pc + ImmExt and discards any wrong-path word, including the response
//   to a request that was already in flight (S_FLUSH).
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   imem_req/imem_addr  request to instruction memory, held until rvalid
//   imem_rvalid/rdata   response for the outstanding request
//   stall               decode cannot accept the output this cycle
//   br_taken/br_pc/ImmExt  redirect from execute
//   if_valid/if_inst/if_pc output register towards decode
//   misalign            one-cycle pulse after a redirect with tgt[1] set
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] ImmExt,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic            misalign
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] hold_inst;
  logic [XLEN-1:0] tgt_aligned;
  logic            misalign_next;
  logic            slot_free;
  logic            fetch_accept;
  logic            hold_release;
  logic            capture_hold;

  branch_target_adder #(.XLEN(XLEN)) u_target (
    .br_taken      (br_taken),
    .br_pc         (br_pc),
    .imm_ext       (ImmExt),
    .tgt_aligned   (tgt_aligned),
    .misalign_next (misalign_next)
  );

  // The output slot can take a new word when it is empty or being consumed.
  assign slot_free = !if_valid || !stall;

  assign fetch_accept = (state == S_FETCH) && !br_taken && imem_rvalid && slot_free;
  assign capture_hold = (state == S_FETCH) && !br_taken && imem_rvalid && !slot_free;
  assign hold_release = (state == S_HOLD)  && !br_taken && slot_free;

  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a redirect always wins over stall
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: begin
        if (br_taken)         state_next = imem_rvalid ? S_FETCH : S_FLUSH;
        else if (capture_hold) state_next = S_HOLD;
      end
      S_HOLD:  if (br_taken || slot_free) state_next = S_FETCH;
      S_FLUSH: if (imem_rvalid) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: a request is outstanding only in FETCH and FLUSH
  always_comb begin
    imem_req = (state == S_FETCH) || (state == S_FLUSH);
  end

  // A redirect while a request is outstanding cannot move the PC until that
  // request completes, because imem_addr must stay stable; the target is
  // parked in pend_pc instead and applied when the stale word returns.
  always_comb begin
    pc_next = pc;
    if (br_taken) begin
      if (!imem_req || imem_rvalid) pc_next = tgt_aligned;
    end else if (fetch_accept || hold_release) begin
      pc_next = pc + XLEN'(4);
    end else if ((state == S_FLUSH) && imem_rvalid) begin
      pc_next = pend_pc;
    end
  end

  // PC, pending redirect target and parked word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      pend_pc   <= '0;
      hold_inst <= '0;
    end else begin
      pc <= pc_next;
      if (br_taken && imem_req && !imem_rvalid) pend_pc <= tgt_aligned;
      if (capture_hold) hold_inst <= imem_rdata;
    end
  end

  // Output register towards decode. The PC of a parked word is still pc,
  // because pc only advances once that word reaches the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_inst  <= XLEN'(NOP_INST);
      if_pc    <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= misalign_next;
      if (br_taken) begin
        if_valid <= 1'b0;
      end else if (fetch_accept) begin
        if_valid <= 1'b1;
        if_inst  <= imem_rdata;
        if_pc    <= pc;
      end else if (hold_release) begin
        if_valid <= 1'b1;
        if_inst  <= hold_inst;
        if_pc    <= pc;
      end else if (slot_free) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage
//   Directed bench for instr_fetch_stage. The main instance (RESET_PC = 0)
//   talks to a memory model with adjustable latency; a second instance with
//   RESET_PC = 32'hFFFF_FFF8 runs against a 1-cycle memory to show the PC
//   wrapping. Memory returns addr ^ WORD_KEY so every word identifies its PC.
module tb_instr_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] WORD_KEY = 32'h5A5A_0003;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] imm_ext = '0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        misalign;

  logic        wrap_req;
  logic [31:0] wrap_addr;
  logic        wrap_rvalid;
  logic [31:0] wrap_rdata;
  logic        wrap_if_valid;
  logic [31:0] wrap_if_inst;
  logic [31:0] wrap_if_pc;
  logic        wrap_misalign;

  int tests_run    = 0;
  int tests_failed = 0;
  int mem_lat      = 1;
  int mem_cnt;

  always #5 clk = ~clk;

  instr_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .br_taken(br_taken), .br_pc(br_pc), .ImmExt(imm_ext),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .misalign(misalign)
  );

  instr_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(wrap_req), .imem_addr(wrap_addr),
    .imem_rvalid(wrap_rvalid), .imem_rdata(wrap_rdata),
    .stall(1'b0), .br_taken(1'b0), .br_pc(32'h0), .ImmExt(32'h0),
    .if_valid(wrap_if_valid), .if_inst(wrap_if_inst), .if_pc(wrap_if_pc),
    .misalign(wrap_misalign)
  );

  // Memory model: the response for a request arrives mem_lat-1 edges after
  // the request first appears (mem_lat = 1 answers in the same cycle).
  always @(posedge clk or posedge rst) begin
    if (rst)                         mem_cnt <= 0;
    else if (imem_req && !imem_rvalid) mem_cnt <= mem_cnt + 1;
    else                             mem_cnt <= 0;
  end

  assign imem_rvalid = imem_req && (mem_cnt == mem_lat - 1);
  assign imem_rdata  = imem_addr ^ WORD_KEY;
  assign wrap_rvalid = wrap_req;
  assign wrap_rdata  = wrap_addr ^ WORD_KEY;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset values on both instances, then the first request after release
  task automatic test_reset;
    tick;
    tick;
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_if_valid: got %b expected 0", if_valid); end
    tests_run++; if (if_inst !== NOP) begin tests_failed++; $display("[TB] FAIL rst_if_inst: got %h expected %h", if_inst, NOP); end
    tests_run++; if (if_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_if_pc: got %h expected 0", if_pc); end
    tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_misalign: got %b expected 0", misalign); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_imem_req: got %b expected 0", imem_req); end
    tests_run++; if (wrap_addr !== 32'hFFFF_FFF8) begin tests_failed++; $display("[TB] FAIL rst_wrap_addr: got %h expected fffffff8", wrap_addr); end
    rst = 1'b0;
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_imem_req: got %b expected 0", imem_req); end
    tick;
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL first_imem_req: got %b expected 1", imem_req); end
    tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL first_imem_addr: got %h expected 0", imem_addr); end
  endtask

  // 1-cycle memory, no stall: one instruction per cycle, PC 0,4,8,...
  // The wrap instance shows FFF8, FFFC, 0000, 0004 in the same cycles.
  task automatic test_sequential;
    logic [31:0] exp_pc;
    logic [31:0] exp_wrap;
    for (int k = 0; k < 6; k++) begin
      tick;
      exp_pc = 32'(4 * k);
      tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL seq_if_valid[%0d]: got %b expected 1", k, if_valid); end
      tests_run++; if (if_pc !== exp_pc) begin tests_failed++; $display("[TB] FAIL seq_if_pc[%0d]: got %h expected %h", k, if_pc, exp_pc); end
      tests_run++; if (if_inst !== (exp_pc ^ WORD_KEY)) begin tests_failed++; $display("[TB] FAIL seq_if_inst[%0d]: got %h expected %h", k, if_inst, exp_pc ^ WORD_KEY); end
      if (k < 4) begin
        exp_wrap = 32'hFFFF_FFF8 + 32'(4 * k);
        tests_run++; if (wrap_if_valid !== 1'b1 || wrap_if_pc !== exp_wrap) begin tests_failed++; $display("[TB] FAIL wrap_if_pc[%0d]: got %b/%h expected 1/%h", k, wrap_if_valid, wrap_if_pc, exp_wrap); end
      end
    end
  endtask

  // Stall for three edges with a word arriving: output holds, word parked,
  // no request; after release 24, 28, 32 come out back to back.
  task automatic test_stall;
    logic [31:0] exp_pc;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'd20) begin tests_failed++; $display("[TB] FAIL stall_hold_out[%0d]: got %b/%h expected 1/00000014", i, if_valid, if_pc); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_imem_req[%0d]: got %b expected 0", i, imem_req); end
      tests_run++; if (dut.state !== S_HOLD) begin tests_failed++; $display("[TB] FAIL stall_state[%0d]: got %0d expected %0d", i, dut.state, S_HOLD); end
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      exp_pc = 32'd24 + 32'(4 * k);
      tests_run++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin tests_failed++; $display("[TB] FAIL stall_release_pc[%0d]: got %b/%h expected 1/%h", k, if_valid, if_pc, exp_pc); end
      tests_run++; if (if_inst !== (exp_pc ^ WORD_KEY)) begin tests_failed++; $display("[TB] FAIL stall_release_inst[%0d]: got %h expected %h", k, if_inst, exp_pc ^ WORD_KEY); end
    end
  endtask

  // 3-cycle memory, redirect while the request for 0x24 is in flight:
  // target 0x100 + 0xFFFFFFF0 = 0xF0, the 0x24 word never reaches decode.
  task automatic test_redirect;
    mem_lat = 3;
    tick;
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_drain_valid: got %b expected 0", if_valid); end
    br_taken = 1'b1;
    br_pc    = 32'h0000_0100;
    imm_ext  = 32'hFFFF_FFF0;
    tick;
    br_taken = 1'b0;
    tests_run++; if (dut.state !== S_FLUSH) begin tests_failed++; $display("[TB] FAIL redir_state: got %0d expected %0d", dut.state, S_FLUSH); end
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin tests_failed++; $display("[TB] FAIL redir_stale_addr: got %b/%h expected 1/00000024", imem_req, imem_addr); end
    tick;
    tests_run++; if (imem_addr !== 32'hF0) begin tests_failed++; $display("[TB] FAIL redir_new_addr: got %h expected 000000f0", imem_addr); end
    tick;
    tick;
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_stale_drop: got %b expected 0", if_valid); end
    tick;
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'hF0) begin tests_failed++; $display("[TB] FAIL redir_first_word: got %b/%h expected 1/000000f0", if_valid, if_pc); end
    tests_run++; if (if_inst !== (32'hF0 ^ WORD_KEY)) begin tests_failed++; $display("[TB] FAIL redir_first_inst: got %h expected %h", if_inst, 32'hF0 ^ WORD_KEY); end
  endtask

  // Redirect on the same cycle as rvalid for 0xF4: word dropped, if_valid
  // cleared on that edge, PC = 0x200 + 0x40 on the next cycle.
  task automatic test_redirect_rvalid;
    mem_lat  = 1;
    br_taken = 1'b1;
    br_pc    = 32'h0000_0200;
    imm_ext  = 32'h0000_0040;
    tick;
    br_taken = 1'b0;
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rv_redir_valid: got %b expected 0", if_valid); end
    tests_run++; if (imem_addr !== 32'h240) begin tests_failed++; $display("[TB] FAIL rv_redir_addr: got %h expected 00000240", imem_addr); end
    tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("[TB] FAIL rv_redir_misalign: got %b expected 0", misalign); end
    tick;
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h240) begin tests_failed++; $display("[TB] FAIL rv_redir_word: got %b/%h expected 1/00000240", if_valid, if_pc); end
  endtask

  // br_pc 0x10 + 6 = 0x16: misalign pulses once, fetch resumes at 0x14
  task automatic test_misalign;
    br_taken = 1'b1;
    br_pc    = 32'h0000_0010;
    imm_ext  = 32'h0000_0006;
    tick;
    br_taken = 1'b0;
    tests_run++; if (misalign !== 1'b1) begin tests_failed++; $display("[TB] FAIL misalign_pulse: got %b expected 1", misalign); end
    tests_run++; if (imem_addr !== 32'h14) begin tests_failed++; $display("[TB] FAIL misalign_addr: got %h expected 00000014", imem_addr); end
    tick;
    tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("[TB] FAIL misalign_clear: got %b expected 0", misalign); end
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h14) begin tests_failed++; $display("[TB] FAIL misalign_word: got %b/%h expected 1/00000014", if_valid, if_pc); end
  endtask

  // Reset asserted between edges in S_FLUSH and again in S_HOLD
  task automatic test_async_reset;
    mem_lat  = 3;
    br_taken = 1'b1;
    br_pc    = 32'h0000_0300;
    imm_ext  = 32'h0;
    tick;
    br_taken = 1'b0;
    tests_run++; if (dut.state !== S_FLUSH) begin tests_failed++; $display("[TB] FAIL ar_flush_state: got %0d expected %0d", dut.state, S_FLUSH); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (if_valid !== 1'b0 || if_inst !== NOP || if_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL ar_flush_out: got %b/%h/%h expected 0/%h/00000000", if_valid, if_inst, if_pc, NOP); end
    tests_run++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || misalign !== 1'b0) begin tests_failed++; $display("[TB] FAIL ar_flush_req: got %b/%h/%b expected 0/00000000/0", imem_req, imem_addr, misalign); end
    tick;
    rst     = 1'b0;
    mem_lat = 1;
    tick;
    tick;
    tick;
    stall = 1'b1;
    tick;
    tests_run++; if (dut.state !== S_HOLD || if_pc !== 32'h4) begin tests_failed++; $display("[TB] FAIL ar_hold_setup: got %0d/%h expected %0d/00000004", dut.state, if_pc, S_HOLD); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (if_valid !== 1'b0 || if_inst !== NOP || if_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL ar_hold_out: got %b/%h/%h expected 0/%h/00000000", if_valid, if_inst, if_pc, NOP); end
    tests_run++; if (imem_req !== 1'b0 || dut.state !== S_IDLE) begin tests_failed++; $display("[TB] FAIL ar_hold_state: got %b/%0d expected 0/%0d", imem_req, dut.state, S_IDLE); end
    stall = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    tick;
    tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL ar_restart: got %b/%h expected 1/00000000", if_valid, if_pc); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_redirect;
    test_redirect_rvalid;
    test_misalign;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
